// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor: D bits per clock over N/D cycles, with
// valid/ready handshakes and unsigned carry/borrow plus signed overflow flags.
module digit_serial_add_sub #(
  parameter int N = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         carry_out,
  output logic         overflow
);

  localparam int DIGITS = (D > 0) ? N / D : 1;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_bad_params
      $error("digit_serial_add_sub: need N >= 2, 1 <= D <= N and N %% D == 0");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   a_sh_reg, a_sh_next;
  logic [N-1:0]   b_sh_reg, b_sh_next;
  logic [N-1:0]   res_reg, res_next;
  logic [N-1:0]   d_reg, d_next;
  logic           carry_reg, carry_next;
  logic           co_reg, co_next;
  logic           ov_reg, ov_next;
  logic [CW-1:0]  cnt_reg, cnt_next;

  logic [D:0]     digit_sum;
  logic [D-1:0]   digit_s;
  logic           msb_cin;
  logic [N-1:0]   res_shifted;

  assign digit_sum = {1'b0, a_sh_reg[D-1:0]} + {1'b0, b_sh_reg[D-1:0]} + {{D{1'b0}}, carry_reg};
  assign digit_s   = digit_sum[D-1:0];
  // Carry into the top bit of the digit, recovered from the sum bit; on the
  // last digit this is the carry into bit N-1.
  assign msb_cin   = a_sh_reg[D-1] ^ b_sh_reg[D-1] ^ digit_s[D-1];

  generate
    if (D == N) begin : g_single_digit
      assign res_shifted = digit_s;
    end else begin : g_multi_digit
      assign res_shifted = {digit_s, res_reg[N-1:D]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      d_reg     <= '0;
      carry_reg <= 1'b0;
      co_reg    <= 1'b0;
      ov_reg    <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      res_reg   <= res_next;
      d_reg     <= d_next;
      carry_reg <= carry_next;
      co_reg    <= co_next;
      ov_reg    <= ov_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    res_next   = res_reg;
    d_next     = d_reg;
    carry_next = carry_reg;
    co_next    = co_reg;
    ov_next    = ov_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, with the +1 entering as the initial carry.
          a_sh_next  = a;
          b_sh_next  = sub ? ~b : b;
          carry_next = sub;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        a_sh_next  = a_sh_reg >> D;
        b_sh_next  = b_sh_reg >> D;
        res_next   = res_shifted;
        carry_next = digit_sum[D];
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CW'(DIGITS - 1)) begin
          d_next     = res_shifted;
          co_next    = digit_sum[D];
          ov_next    = msb_cin ^ digit_sum[D];
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign d         = d_reg;
  assign carry_out = co_reg;
  assign overflow  = ov_reg;

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Bench for digit_serial_add_sub: directed N=16/D=4 cases plus parallel
// randomised sweeps over several (N,D) against a golden arithmetic model.
module tb_digit_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [65:0] gold(input int n, input longint unsigned ga,
                                       input longint unsigned gb, input bit gs);
    longint unsigned mask, bb, full, dd;
    bit co, ov, as_, bs_, ds_;
    mask = (64'd1 << n) - 64'd1;
    bb   = gs ? (~gb & mask) : gb;
    full = ga + bb + (gs ? 64'd1 : 64'd0);
    dd   = full & mask;
    co   = ((full >> n) & 64'd1) != 0;
    as_  = ((ga >> (n - 1)) & 64'd1) != 0;
    bs_  = ((gb >> (n - 1)) & 64'd1) != 0;
    ds_  = ((dd >> (n - 1)) & 64'd1) != 0;
    ov   = gs ? (as_ != bs_ && ds_ != as_) : (as_ == bs_ && ds_ != as_);
    return {ov, co, dd};
  endfunction

  function automatic longint unsigned pick(input int n);
    longint unsigned mask, r;
    mask = (64'd1 << n) - 64'd1;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       r = 64'd0;
      1:       r = mask;
      2:       r = 64'd1 << (n - 1);
      3:       r = (64'd1 << (n - 1)) - 64'd1;
      default: ;
    endcase
    return r & mask;
  endfunction

  // ---------------- directed DUT, N=16 D=4 ----------------
  logic        m_rst_n, m_in_valid, m_in_ready, m_sub, m_out_valid, m_out_ready, m_co, m_ov;
  logic [15:0] m_a, m_b, m_d;
  logic [17:0] m_q[$];

  digit_serial_add_sub #(.N(16), .D(4)) u_dut (
    .clk(clk), .rst_n(m_rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .sub(m_sub), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .d(m_d), .carry_out(m_co), .overflow(m_ov)
  );

  task automatic main_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                         input logic [15:0] ed, input logic eco, input logic eov, input int hold);
    logic [17:0] e;
    int lat;
    @(negedge clk);
    m_a = ta; m_b = tb_; m_sub = ts; m_in_valid = 1'b1;
    chk("accept_in_ready", m_in_ready, 1);
    m_q.push_back({ed, eco, eov});
    @(negedge clk);
    m_in_valid = 1'b0;
    m_a = 16'($urandom); m_b = 16'($urandom); m_sub = ~ts;
    lat = 0;
    while (!m_out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 4);
    e = m_q.pop_front();
    chk("d", m_d, e[17:2]);
    chk("carry_out", m_co, e[1]);
    chk("overflow", m_ov, e[0]);
    $display("op a=%04h b=%04h sub=%0d -> d=%04h co=%0d ov=%0d lat=%0d", ta, tb_, ts, m_d, m_co, m_ov, lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_d", m_d, e[17:2]);
      chk("hold_co", m_co, e[1]);
      chk("hold_ov", m_ov, e[0]);
      chk("hold_in_ready", m_in_ready, 0);
      chk("hold_out_valid", m_out_valid, 1);
      m_in_valid = (i == 1);
      m_a = 16'hDEAD; m_b = 16'hBEEF;
    end
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    @(negedge clk);
    m_out_ready = 1'b0;
    chk("idle_in_ready", m_in_ready, 1);
    chk("idle_out_valid", m_out_valid, 0);
  endtask

  // ---------------- randomised sweeps ----------------
  localparam int SW_N [4] = '{16, 16, 8, 32};
  localparam int SW_D [4] = '{1, 16, 2, 8};
  localparam int SW_OPS   = 2000;
  bit sw_fin [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sw
      localparam int NN = SW_N[gi];
      localparam int DD = SW_D[gi];
      logic          s_rst_n, s_in_valid, s_in_ready, s_sub, s_out_valid, s_out_ready, s_co, s_ov;
      logic [NN-1:0] s_a, s_b, s_d;
      logic [NN+1:0] s_q[$];
      int            s_acc_q[$];

      digit_serial_add_sub #(.N(NN), .D(DD)) u_sw (
        .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .sub(s_sub), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .d(s_d), .carry_out(s_co), .overflow(s_ov)
      );

      initial begin
        int sent, recv, guard, acc;
        bit seen;
        logic [65:0] g;
        logic [NN+1:0] e;
        longint unsigned va, vb;
        sent = 0; recv = 0; guard = 0; seen = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0;
        s_rst_n = 1'b1;
        #2 s_rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        s_rst_n = 1'b1;
        while (recv < SW_OPS && guard < 90000) begin
          @(negedge clk);
          guard++;
          if (s_out_valid && !seen) begin
            chk("sw_sb_nonempty", s_q.size() > 0, 1);
            if (s_q.size() > 0) begin
              e   = s_q.pop_front();
              acc = s_acc_q.pop_front();
              chk("sw_d", s_d, e[NN-1:0]);
              chk("sw_carry_out", s_co, e[NN]);
              chk("sw_overflow", s_ov, e[NN+1]);
              chk("sw_latency", cyc - acc, NN / DD);
              $display("sweep N=%0d D=%0d d=%0h co=%0d ov=%0d", NN, DD, s_d, s_co, s_ov);
            end
            seen = 1'b1;
          end
          s_out_ready = ($urandom_range(0, 3) != 0);
          if (s_out_valid && s_out_ready) begin
            seen = 1'b0;
            recv++;
          end
          va = pick(NN); vb = pick(NN);
          s_a = va[NN-1:0]; s_b = vb[NN-1:0]; s_sub = 1'($urandom_range(0, 1));
          s_in_valid = (sent < SW_OPS) && ($urandom_range(0, 3) != 0);
          if (s_in_valid && s_in_ready) begin
            g = gold(NN, va, vb, s_sub);
            s_q.push_back({g[65], g[64], g[NN-1:0]});
            s_acc_q.push_back(cyc + 1);
            sent++;
          end
        end
        s_in_valid = 1'b0;
        chk("sw_completed", recv, SW_OPS);
        sw_fin[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin
    int guard;
    m_rst_n = 1'b1; m_in_valid = 1'b0; m_out_ready = 1'b0;
    m_a = '0; m_b = '0; m_sub = 1'b0;
    #2 m_rst_n = 1'b0;
    #1;
    chk("rst_in_ready", m_in_ready, 1);
    chk("rst_out_valid", m_out_valid, 0);
    chk("rst_d", m_d, 0);
    chk("rst_carry_out", m_co, 0);
    chk("rst_overflow", m_ov, 0);
    @(negedge clk);
    @(negedge clk);
    m_rst_n = 1'b1;

    main_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0);
    main_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    main_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    main_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    main_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    main_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 5);
    main_op(16'h0100, 16'h0001, 1'b1, 16'h00FF, 1'b1, 1'b0, 0);
    main_op(16'hABCD, 16'h0000, 1'b1, 16'hABCD, 1'b1, 1'b0, 0);
    main_op(16'h0001, 16'h8000, 1'b1, 16'h8001, 1'b0, 1'b1, 0);

    // Reset two cycles into a run: the partial result must never appear.
    @(negedge clk);
    m_a = 16'h1234; m_b = 16'h1111; m_sub = 1'b0; m_in_valid = 1'b1;
    @(posedge clk);
    #1 m_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 m_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", m_out_valid, 0);
    chk("midrst_d", m_d, 0);
    chk("midrst_in_ready", m_in_ready, 1);
    chk("midrst_carry_out", m_co, 0);
    chk("midrst_overflow", m_ov, 0);
    @(negedge clk);
    m_rst_n = 1'b1;
    main_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    guard = 0;
    while (!(sw_fin[0] && sw_fin[1] && sw_fin[2] && sw_fin[3]) && guard < 95000) begin
      @(negedge clk);
      guard++;
    end
    chk("sweeps_finished", sw_fin[0] && sw_fin[1] && sw_fin[2] && sw_fin[3], 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/digit_serial_add_sub.md
Name: digit_serial_add_sub

Overview:
- Parametrised, multi-cycle adder/subtractor; successor to the combinational negate/subtract blocks.
- Processes D bits per clock over N/D cycles, trading latency for a D-bit-wide adder core.
- Selects add or subtract per transaction and reports unsigned carry/borrow and signed overflow.
- Valid/ready handshakes on both input and output; sits between operand sources and datapath consumers in the arithmetic building-block library.

Parameters:
- N, 16, operand/result width in bits; N >= 2.
- D, 4, digit width processed per cycle; 1 <= D <= N, N % D == 0 (elaboration error otherwise).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- in_valid, input, 1, operand transaction valid.
- in_ready, output, 1, block can accept operands.
- a, input, N, first operand.
- b, input, N, second operand.
- sub, input, 1, 0 = a+b, 1 = a-b; sampled with operands.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- d, output, N, sum/difference modulo 2^N.
- carry_out, output, 1, carry out of MSB; for sub, 1 = no borrow (a >= b unsigned).
- overflow, output, 1, two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; out_valid=0, d=0, carry_out=0, overflow=0; in_ready=1 as soon as reset asserts; in-flight operation discarded, no partial result ever presented.
- FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on in_valid&&in_ready edge:
  - latch A_sh=a and B_sh = sub ? ~b : b;
  - carry = sub;
  - digit counter = 0;
  - go RUN.
  - No handshake: hold.
- RUN, each edge:
  - {c,s} = A_sh[D-1:0] + B_sh[D-1:0] + carry (D+1-bit sum);
  - shift s into the result register from the MSB end; shift A_sh/B_sh right by D;
  - carry = c; counter++.
  - On the edge where counter == N/D-1:
    - latch carry_out = c;
    - overflow = carry into bit N-1 XOR carry out of bit N-1 (computed inside the final digit);
    - d = completed result;
    - go DONE.
- Latency: out_valid rises exactly N/D cycles after the accepting edge; D==N gives 1 cycle.
- DONE: d, carry_out and overflow held stable while out_valid=1 and out_ready=0. On out_valid&&out_ready edge: go IDLE. d, carry_out and overflow retain their last values, but are meaningful only while out_valid=1.
- No accept in the same cycle as output handshake (in_ready=0 in DONE).
- Throughput: one transaction per N/D+2 cycles with out_ready held high.
- in_valid while not in IDLE: ignored; a, b and sub changes outside the accepting edge have no effect.
- in_valid and out_ready are permitted to change arbitrarily; a transfer occurs only on valid&&ready at an edge.
- Arithmetic: result is modulo 2^N.
  - sub=1 with b=0: d=a, carry_out=1, overflow=0.
  - sub=1 with b=2^(N-1), a >= 0 signed: overflow=1.

Test Plan:
- N=16, D=4, a=0x1234, b=0x0FFF, sub=0 -> out_valid exactly 4 cycles after accept; d=0x2233, carry_out=0, overflow=0.
- sub=1, a=0x0005, b=0x0007 -> d=0xFFFE, carry_out=0 (borrow), overflow=0. Then a=0xFFFF, b=0x0001, sub=0 -> d=0x0000, carry_out=1, overflow=0.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> d=0x8000, overflow=1, carry_out=0. Then a=0x8000, b=0x0001, sub=1 -> d=0x7FFF, overflow=1, carry_out=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> d, carry_out and overflow stable; in_ready=0; a pulsed in_valid with new operands is ignored. Raise out_ready -> IDLE next cycle, in_ready=1; next operation computes correctly.
- Reset mid-RUN: assert rst_n=0 two cycles after accept, asynchronous to the edge -> immediately out_valid=0, d=0, in_ready=1. After release, a=0x0001, b=0x0001, sub=0 -> d=0x0002.
- Parameter sweep: (N,D) = (16,1), (16,16), (8,2), (32,8), 2000 random a/b/sub each with random in_valid/out_ready gaps, checked against a golden model:
  - d = (a ± b) mod 2^N;
  - carry_out and overflow as specified;
  - latency = N/D in every case.
